// File: rtl/uart_rx_controller.sv
// UART receive sequencer: synchronises rx, times start/data/stop bits, emits one byte per good frame.
// Optional even-parity bit between data and stop is enabled by defining UART_RX_PARITY_EN.
module uart_rx_controller #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy,
    output logic [3:0]           bit_count
);

    localparam logic [15:0] HALF_RELOAD = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_RELOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  BITS_FULL   = 4'(DATA_BITS);
    localparam logic [3:0]  BITS_LAST   = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY    = 3'd3,
`endif
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

`ifdef UART_RX_PARITY_EN
    // Even parity holds when data plus parity bit have an even number of ones.
    function automatic logic even_parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
        return ~(^{d, p});
    endfunction
`endif

    state_t                 state_r, state_next_s;
    logic [1:0]             sync_r;
    logic                   rx_s;
    logic                   tick_s;
    logic [15:0]            baud_cnt_r, baud_next_s;
    logic [3:0]             bit_count_r, bit_next_s;
    logic [DATA_BITS-1:0]   shift_r, shift_next_s;
    logic [DATA_BITS-1:0]   rx_data_r, data_next_s;
    logic                   rx_valid_r, valid_next_s;
    logic                   frame_err_r, ferr_next_s;
    logic                   busy_r;
`ifdef UART_RX_PARITY_EN
    logic                   parity_err_r, perr_next_s;
    logic                   parity_ok_r, pok_next_s;
`endif

    assign rx_s   = sync_r[1];
    assign tick_s = (baud_cnt_r == 16'd0);

    // State, counters, datapath and output pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            sync_r       <= 2'b11;
            baud_cnt_r   <= 16'd0;
            bit_count_r  <= 4'd0;
            shift_r      <= '0;
            rx_data_r    <= '0;
            rx_valid_r   <= 1'b0;
            frame_err_r  <= 1'b0;
            busy_r       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_r <= 1'b0;
            parity_ok_r  <= 1'b0;
`endif
        end else begin
            state_r      <= state_next_s;
            sync_r       <= {sync_r[0], rx};
            baud_cnt_r   <= baud_next_s;
            bit_count_r  <= bit_next_s;
            shift_r      <= shift_next_s;
            rx_data_r    <= data_next_s;
            rx_valid_r   <= valid_next_s;
            frame_err_r  <= ferr_next_s;
            busy_r       <= (state_next_s != IDLE);
`ifdef UART_RX_PARITY_EN
            parity_err_r <= perr_next_s;
            parity_ok_r  <= pok_next_s;
`endif
        end
    end

    // Next-state, counter reloads and pulse generation.
    always_comb begin
        state_next_s = state_r;
        baud_next_s  = tick_s ? 16'd0 : baud_cnt_r - 16'd1;
        bit_next_s   = bit_count_r;
        shift_next_s = shift_r;
        data_next_s  = rx_data_r;
        valid_next_s = 1'b0;
        ferr_next_s  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_next_s  = 1'b0;
        pok_next_s   = parity_ok_r;
`endif
        case (state_r)
            IDLE: begin
                baud_next_s = 16'd0;
                if (!rx_s) begin
                    state_next_s = START;
                    baud_next_s  = HALF_RELOAD;
                    bit_next_s   = 4'd0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (tick_s) begin
                    if (!rx_s) begin
                        state_next_s = DATA;
                        baud_next_s  = FULL_RELOAD;
                    end else begin
                        state_next_s = IDLE;
                        baud_next_s  = 16'd0;
                    end
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                if (tick_s) begin
                    shift_next_s = {rx_s, shift_r[DATA_BITS-1:1]};
                    bit_next_s   = (bit_count_r != BITS_FULL) ? bit_count_r + 4'd1 : bit_count_r;
                    baud_next_s  = FULL_RELOAD;
                    if (bit_count_r == BITS_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_next_s = PARITY;
`else
                        state_next_s = STOP;
`endif
                    end else begin
                        state_next_s = DATA;
                    end
                end else begin
                    state_next_s = DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick_s) begin
                    pok_next_s   = even_parity_ok(shift_r, rx_s);
                    state_next_s = STOP;
                    baud_next_s  = FULL_RELOAD;
                end else begin
                    state_next_s = PARITY;
                end
            end
`endif
            STOP: begin
                if (tick_s) begin
                    baud_next_s = 16'd0;
                    if (rx_s) begin
                        state_next_s = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (parity_ok_r) begin
                            data_next_s  = shift_r;
                            valid_next_s = 1'b1;
                        end else begin
                            perr_next_s  = 1'b1;
                        end
`else
                        data_next_s  = shift_r;
                        valid_next_s = 1'b1;
`endif
                    end else begin
                        state_next_s = WAIT_IDLE;
                        ferr_next_s  = 1'b1;
                    end
                end else begin
                    state_next_s = STOP;
                end
            end
            WAIT_IDLE: begin
                baud_next_s = 16'd0;
                if (rx_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT_IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
                baud_next_s  = 16'd0;
            end
        endcase
    end

    assign rx_data    = rx_data_r;
    assign rx_valid   = rx_valid_r;
    assign frame_err  = frame_err_r;
    assign busy       = busy_r;
    assign bit_count  = bit_count_r;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_r;
`else
    assign parity_err = 1'b0;
`endif

endmodule
